// File: rtl/ssub_pkg.sv
// Shared definitions for the bit-serial word subtractor: FSM encoding and default width.
package ssub_pkg;

    localparam int unsigned DEFAULT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/ssub_bit.sv
// One-bit serial subtractor cell: difference bit plus the registered borrow.
module ssub_bit (
    input  logic clk,
    input  logic rst_b,
    input  logic en,
    input  logic clr,
    input  logic x,
    input  logic y,
    output logic d,
    output logic br
);

    logic br_q;
    logic br_next;

    assign d       = x ^ y ^ br_q;
    assign br_next = (~x & y) | (~(x ^ y) & br_q);
    assign br      = br_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            br_q <= 1'b0;
        end else if (clr) begin
            br_q <= 1'b0;
        end else if (en) begin
            br_q <= br_next;
        end
    end

endmodule

// File: rtl/ssub_word.sv
// Word-level bit-serial subtractor, diff = a - b mod 2^W, LSB first.
// Define SSUB_OVF_EN to register a signed-overflow flag; otherwise ovf is tied low.
module ssub_word
    import ssub_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         z,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out,
    output logic         ovf
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   a_sh_q, b_sh_q, diff_q;
    logic [CW-1:0]  cnt_q;
    logic           accept, shift_en, last_bit;
    logic           bit_d, bit_br;

    assign accept   = (state_q == S_IDLE) && start;
    assign shift_en = (state_q == S_SHIFT);
    assign last_bit = shift_en && (cnt_q == CNT_LAST);

    ssub_bit u_bit (
        .clk   (clk),
        .rst_b (rst_b),
        .en    (shift_en),
        .clr   (accept),
        .x     (a_sh_q[0]),
        .y     (b_sh_q[0]),
        .d     (bit_d),
        .br    (bit_br)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sh_q <= a;
                b_sh_q <= b;
                cnt_q  <= '0;
            end else if (shift_en) begin
                a_sh_q <= a_sh_q >> 1;
                b_sh_q <= b_sh_q >> 1;
                diff_q <= {bit_d, diff_q[W-1:1]};
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end

    // The borrow cell stops updating after the last shift, so it already holds the final borrow.
    assign borrow_out = bit_br;
    assign diff       = diff_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign z          = shift_en ? bit_d : 1'b0;

`ifdef SSUB_OVF_EN
    logic ovf_q;

    // On the last shift the operand shifters present the latched MSBs at bit 0.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= (a_sh_q[0] != b_sh_q[0]) && (bit_d != a_sh_q[0]);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ssub_word.sv
// Self-checking bench for ssub_word: arithmetic reference model plus directed vectors.
module tb_ssub_word;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, z, done, borrow_out, ovf;
    logic [W-1:0] diff;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ssub_word #(.W(W)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .z          (z),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain integer subtraction and signed range check.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SSUB_OVF_EN
        int sx, sy, r;
        sx = $signed(x);
        sy = $signed(y);
        r  = sx - sy;
        return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic ref_zbit(input logic [W-1:0] x, input logic [W-1:0] y, input int p);
        logic [W-1:0] t;
        t = x - y;
        return t[p];
    endfunction

    // Model: phase 0 idle, 1..W serial cycles, W+1 done.
    int           m_phase = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_diff_held = '0;
    logic         m_br_held = 1'b0, m_ovf_held = 1'b0;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_phase     <= 0;
            m_diff_held <= '0;
            m_br_held   <= 1'b0;
            m_ovf_held  <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase    <= 1;
                m_a        <= a;
                m_b        <= b;
                m_ovf_held <= 1'b0;
            end
        end else if (m_phase == W) begin
            m_phase     <= W + 1;
            m_diff_held <= m_a - m_b;
            m_br_held   <= (m_a < m_b);
            m_ovf_held  <= ref_ovf(m_a, m_b);
        end else if (m_phase == W + 1) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_phase != 0);
        chk("done", done, m_phase == W + 1);
        chk("z", z, (m_phase >= 1 && m_phase <= W) ? ref_zbit(m_a, m_b, m_phase - 1) : 1'b0);
        chk("ovf", ovf, m_ovf_held);
        if (m_phase == 0 || m_phase == W + 1) begin
            chk("diff", diff, m_diff_held);
            chk("borrow_out", borrow_out, m_br_held);
        end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         output logic [W-1:0] rd, output logic rbr, output logic rovf,
                         output int lat, output logic [W-1:0] zs);
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        zs = '0;
        while (!done && lat < 30) begin
            if (lat <= W) zs[lat-1] = z;
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", done, 1'b1);
        rd = diff;
        rbr = borrow_out;
        rovf = ovf;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rd, zs;
        logic         rbr, rovf;
        int           lat, idx, first_done, n_done;
        logic [W-1:0] b2b_a [3];
        logic [W-1:0] b2b_b [3];
        logic [W-1:0] b2b_d [3];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_z", z, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_borrow", borrow_out, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst_b = 1'b1;

        do_op(8'h05, 8'h03, rd, rbr, rovf, lat, zs);
        chk("5-3 diff", rd, 8'h02);
        chk("5-3 borrow", rbr, 1'b0);
        chk("5-3 zseq", zs, 8'b0000_0010);
        chk("5-3 latency", lat, W + 1);

        do_op(8'h03, 8'h05, rd, rbr, rovf, lat, zs);
        chk("3-5 diff", rd, 8'hFE);
        chk("3-5 borrow", rbr, 1'b1);

        do_op(8'h00, 8'h01, rd, rbr, rovf, lat, zs);
        chk("0-1 diff", rd, 8'hFF);
        chk("0-1 borrow", rbr, 1'b1);
        chk("0-1 zseq", zs, 8'hFF);

        do_op(8'hA5, 8'hA5, rd, rbr, rovf, lat, zs);
        chk("a=b diff", rd, 8'h00);
        chk("a=b borrow", rbr, 1'b0);

        do_op(8'h80, 8'h01, rd, rbr, rovf, lat, zs);
        chk("80-01 diff", rd, 8'h7F);
`ifdef SSUB_OVF_EN
        chk("80-01 ovf", rovf, 1'b1);
`else
        chk("80-01 ovf", rovf, 1'b0);
`endif
        do_op(8'h10, 8'h01, rd, rbr, rovf, lat, zs);
        chk("10-01 diff", rd, 8'h0F);
        chk("10-01 ovf", rovf, 1'b0);

        // start re-pulsed mid-operation must be ignored
        @(negedge clk);
        a = 8'h30;
        b = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 30) begin
            chk("midstart_busy", busy, 1'b1);
            @(negedge clk);
            lat++;
        end
        chk("midstart diff", diff, 8'h1F);
        chk("midstart borrow", borrow_out, 1'b0);

        // Asynchronous reset after the 4th shift edge
        @(negedge clk);
        a = 8'h05;
        b = 8'h03;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_b = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_diff", diff, 8'h00);
        chk("arst_z", z, 1'b0);
        chk("arst_done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        do_op(8'h05, 8'h03, rd, rbr, rovf, lat, zs);
        chk("post-rst diff", rd, 8'h02);

        // Back-to-back with start held high
        b2b_a[0] = 8'h40; b2b_b[0] = 8'h01; b2b_d[0] = 8'h3F;
        b2b_a[1] = 8'h01; b2b_b[1] = 8'h02; b2b_d[1] = 8'hFF;
        b2b_a[2] = 8'h7F; b2b_b[2] = 8'h7F; b2b_d[2] = 8'h00;
        @(negedge clk);
        a = b2b_a[0];
        b = b2b_b[0];
        start = 1'b1;
        n_done = 0;
        first_done = 0;
        idx = 0;
        while (n_done < 3 && idx < 60) begin
            @(negedge clk);
            idx++;
            if (done) begin
                chk("b2b diff", diff, b2b_d[n_done]);
                if (n_done > 0) chk("b2b spacing", idx - first_done, (W + 2) * n_done);
                else first_done = idx;
                n_done++;
                if (n_done < 3) begin
                    a = b2b_a[n_done];
                    b = b2b_b[n_done];
                end else begin
                    start = 1'b0;
                end
            end
        end
        chk("b2b count", n_done, 3);
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
